row_buff_pack: RTL and testbench
================================

Name: row_buff_pack

Overview:
- Parametrised row buffer feeding the matrix datapath.
- Packs a stream of SLICE_W-bit slices into one row of SLICES slices.
- A row closes early on an end marker; missing slots are zero-filled.
- Double buffered (fill register + output register) with valid/ready on both sides, so a full-rate stream sees no stalls while the consumer keeps up.
- Sits between the slice source and matrix_mdl; replaces the fixed-width row buffer.

Parameters:
- SLICE_W, 1024, width of one input slice in bits.
- SLICES, 8, slices per row; legal range 2..64.
- CNT_W, $clog2(SLICES+1), width of the slice-count fields (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data/in_last valid this cycle.
- in_ready  out  1  block accepts a slice this cycle.
- in_data  in  SLICE_W  slice payload.
- in_last  in  1  this slice ends the row (early close).
- out_valid  out  1  out_data holds a complete row.
- out_ready  in  1  consumer takes the row this cycle.
- out_data  out  SLICE_W*SLICES  packed row; slot k occupies bits [k*SLICE_W +: SLICE_W].
- out_count  out  CNT_W  number of real slices in the row, 1..SLICES.
- out_short  out  1  row was closed by in_last before SLICES slices.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - out_valid=0, out_data=0, out_count=0, out_short=0.
  - Fill register zeroed; fill count=0; state=FILL.
  - in_ready goes high on the first cycle after reset release.
- Accept and xfer:
  - accept = in_valid & in_ready.
  - xfer = fill-to-output transfer, allowed when !out_valid | out_ready.
- Packing:
  - The first slice of a row goes to slot 0 (LSBs); each accepted slice goes to slot fill count, then the count increments.
  - Unwritten slots read 0.
- Row close: the row closes on the accept where count reaches SLICES, or on any accept with in_last=1.
- FSM FILL:
  - in_ready=1.
  - On a closing accept: if xfer is allowed in the same cycle, the row (including this slice) moves to the output register at that edge.
  - out_valid=1 in the next cycle (1-cycle latency).
  - The fill register clears, count=0, and the state stays FILL.
  - Otherwise go to PEND.
- FSM PEND:
  - in_ready=0; the fill register holds the completed row.
  - When xfer is allowed, move the row to the output register, clear the fill register, and return to FILL.
  - in_ready is high again in the following cycle.
- Output handshake:
  - out_data, out_count and out_short are stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready with no transfer pending → out_valid=0 next cycle; out_data keeps its value.
  - Simultaneous consume + transfer → out_valid stays 1 and the new row appears next cycle (back-to-back rows, no bubble).
- Boundaries:
  - in_last on the SLICES-th slice → out_short=0, out_count=SLICES.
  - in_last on the first slice → out_count=1, slots 1..SLICES-1 zero.
  - in_valid while in_ready=0 is ignored; the data is not captured and the source must hold it.
  - Count never exceeds SLICES.
- Reset mid-row: the partial row is discarded, a pending or held row is lost, and all outputs return to reset values immediately (async).
- Arithmetic: count is unsigned CNT_W and increments without wrap; a close always returns it to 0.

Optional Feature:
- Macro: ROW_BUFF_STATS_EN.
- With the macro defined, add two outputs:
  - stat_rows (32 bits): increments on each fill-to-output transfer.
  - stat_short (32 bits): increments on each transfer with out_short=1.
- Both counters reset to 0, wrap modulo 2^32, and are observable one cycle after the transfer.
- Without the macro, these ports and registers do not exist and all other behaviour is identical.

Decomposition:
- Shared package row_buff_pkg: the FSM state encoding (FILL=1'b0, PEND=1'b1), the SLICES legality check constant, and the stats width constant (32).
- One sub-module: row_buff_slot_wr, the fill register with slot-indexed write and clear.
- The FSM and the output register stay in the top level.

Test Plan:
All scenarios use SLICE_W=8, SLICES=4.
- Reset check: hold reset=0 → out_valid=0, out_data=0, out_count=0. Release reset → in_ready=1 next cycle.
- Full row: send 0x11,0x22,0x33,0x44 back-to-back with out_ready=1 → one cycle after the 4th accept: out_data=0x44332211, out_count=4, out_short=0.
- Short row: send 0xA1,0xB2 with in_last on 0xB2 → out_data=0x0000B2A1, out_count=2, out_short=1.
- Back-pressure:
  - Hold out_ready=0 and stream 8 slices → the first row is held.
  - After the 8th slice in_ready=0 (PEND), and a 9th slice is not captured.
  - Raise out_ready for 1 cycle → out_data=second row next cycle, and in_ready returns to 1 the cycle after.
- Throughput: 12 slices streamed continuously with out_ready=1 → in_ready never drops and out_valid pulses every 4 cycles, with 3 correct rows.
- Reset mid-row:
  - Accept 0x55,0x66, then pulse reset.
  - Next, send 0x01,0x02,0x03,0x04 → out_data=0x04030201 (no stale slices).
  - With ROW_BUFF_STATS_EN: stat_rows=1, stat_short=0.

Source files
------------

// File: rtl/row_buff_pkg.sv
// Shared definitions for the row buffer: FSM encoding, the legal SLICES range
// and the width of the optional statistics counters.
package row_buff_pkg;

   typedef enum logic {
      FILL = 1'b0,
      PEND = 1'b1
   } rowState_t;

   localparam int SLICES_MIN = 2;
   localparam int SLICES_MAX = 64;
   localparam int STATS_W    = 32;

   function automatic bit slicesLegal(input int slices);
      return (slices >= SLICES_MIN) && (slices <= SLICES_MAX);
   endfunction

endpackage

// File: rtl/row_buff_slot_wr.sv
// Fill register of the row buffer: one slot written per accepted slice,
// whole row cleared when it moves to the output register.
module row_buff_slot_wr
   import row_buff_pkg::*;
#(
   parameter int SLICE_W = 1024,
   parameter int SLICES  = 8,
   parameter int CNT_W   = $clog2(SLICES + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       wrEn,
   input  logic [CNT_W-1:0]           wrIdx,
   input  logic [SLICE_W-1:0]         wrData,
   input  logic                       clear,
   output logic [SLICE_W*SLICES-1:0]  mergedRow
);

   logic [SLICE_W-1:0] slotReg [SLICES];

   for (genvar k = 0; k < SLICES; k++) begin : gSlot
      logic slotHit;
      assign slotHit = wrEn && (wrIdx == CNT_W'(k));

      // Clear wins over write: a closing slice bypasses the register and is
      // picked up through mergedRow instead.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            slotReg[k] <= '0;
         end else if (clear) begin
            slotReg[k] <= '0;
         end else if (slotHit) begin
            slotReg[k] <= wrData;
         end
      end

      assign mergedRow[k*SLICE_W +: SLICE_W] = slotHit ? wrData : slotReg[k];
   end

endmodule

// File: rtl/row_buff_pack.sv
// Packs a stream of slices into rows with early close on in_last.
// Optional statistics counters are enabled with `define ROW_BUFF_STATS_EN.
module row_buff_pack
   import row_buff_pkg::*;
#(
   parameter int SLICE_W = 1024,
   parameter int SLICES  = 8,
   parameter int CNT_W   = $clog2(SLICES + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SLICE_W-1:0]         in_data,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SLICE_W*SLICES-1:0]  out_data,
   output logic [CNT_W-1:0]           out_count,
   output logic                       out_short
`ifdef ROW_BUFF_STATS_EN
   ,
   output logic [STATS_W-1:0]         stat_rows,
   output logic [STATS_W-1:0]         stat_short
`endif
);

   if (!slicesLegal(SLICES)) begin : gBadSlices
      $error("row_buff_pack: SLICES must lie in 2..64");
   end

   rowState_t                  state;
   rowState_t                  stateNext;
   logic [CNT_W-1:0]           fillCount;
   logic [CNT_W-1:0]           cntInc;
   logic [CNT_W-1:0]           loadCount;
   logic                       pendShort;
   logic                       accept;
   logic                       fillClose;
   logic                       isShort;
   logic                       xferOk;
   logic                       loadOut;
   logic                       loadShort;
   logic [SLICE_W*SLICES-1:0]  mergedRow;

   assign cntInc    = fillCount + CNT_W'(1);
   assign accept    = in_valid & in_ready;
   assign fillClose = in_valid & (in_last | (cntInc == CNT_W'(SLICES)));
   assign isShort   = in_last & (cntInc != CNT_W'(SLICES));
   assign xferOk    = !out_valid | out_ready;
   assign loadCount = (state == PEND) ? fillCount : cntInc;
   assign loadShort = (state == PEND) ? pendShort : isShort;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= FILL;
      end else begin
         state <= stateNext;
      end
   end

   // A closing slice goes straight to the output when it is free; otherwise
   // the finished row parks in the fill register until the consumer drains.
   always_comb begin
      stateNext = state;
      in_ready  = 1'b0;
      loadOut   = 1'b0;
      case (state)
         FILL: begin
            in_ready = 1'b1;
            if (fillClose) begin
               if (xferOk) begin
                  loadOut = 1'b1;
               end else begin
                  stateNext = PEND;
               end
            end
         end
         PEND: begin
            if (xferOk) begin
               loadOut   = 1'b1;
               stateNext = FILL;
            end
         end
         default: stateNext = FILL;
      endcase
   end

   // While parked, fillCount keeps the final count of the pending row.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fillCount <= '0;
         pendShort <= 1'b0;
      end else begin
         if (loadOut) begin
            fillCount <= '0;
         end else if (accept) begin
            fillCount <= cntInc;
         end
         if (accept) begin
            pendShort <= isShort;
         end
      end
   end

   row_buff_slot_wr #(
      .SLICE_W (SLICE_W),
      .SLICES  (SLICES),
      .CNT_W   (CNT_W)
   ) uSlotWr (
      .clock     (clock),
      .reset     (reset),
      .wrEn      (accept),
      .wrIdx     (fillCount),
      .wrData    (in_data),
      .clear     (loadOut),
      .mergedRow (mergedRow)
   );

   // Output register: a load while the consumer takes the old row keeps
   // out_valid high, giving back-to-back rows without a bubble.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_short <= 1'b0;
      end else if (loadOut) begin
         out_valid <= 1'b1;
         out_data  <= mergedRow;
         out_count <= loadCount;
         out_short <= loadShort;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ROW_BUFF_STATS_EN
   // Counters wrap naturally at 2^32.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_rows  <= '0;
         stat_short <= '0;
      end else if (loadOut) begin
         stat_rows <= stat_rows + STATS_W'(1);
         if (loadShort) begin
            stat_short <= stat_short + STATS_W'(1);
         end
      end
   end
`else
   // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_row_buff_pack.sv
// Directed, table-driven bench for row_buff_pack with SLICE_W=8, SLICES=4.
module tb_row_buff_pack;

   localparam int SLICE_W = 8;
   localparam int SLICES  = 4;
   localparam int CNT_W   = $clog2(SLICES + 1);

   logic                      clock = 1'b0;
   logic                      reset = 1'b0;
   logic                      inValid = 1'b0;
   logic                      inReady;
   logic [SLICE_W-1:0]        inData = '0;
   logic                      inLast = 1'b0;
   logic                      outValid;
   logic                      outReady = 1'b0;
   logic [SLICE_W*SLICES-1:0] outData;
   logic [CNT_W-1:0]          outCount;
   logic                      outShort;
`ifdef ROW_BUFF_STATS_EN
   logic [31:0]               statRows;
   logic [31:0]               statShort;
`endif

   int nChecks = 0;
   int nFails  = 0;

   always #5 clock = ~clock;

   row_buff_pack #(
      .SLICE_W (SLICE_W),
      .SLICES  (SLICES)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_data   (inData),
      .in_last   (inLast),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_data  (outData),
      .out_count (outCount),
      .out_short (outShort)
`ifdef ROW_BUFF_STATS_EN
      ,
      .stat_rows  (statRows),
      .stat_short (statShort)
`endif
   );

   typedef struct {
      logic        inValid;
      logic [7:0]  inData;
      logic        inLast;
      logic        outReady;
      logic        expReady;
      logic        expValid;
      logic [31:0] expData;
      logic [2:0]  expCount;
      logic        expShort;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input logic vi, input logic [7:0] d, input logic l,
                         input logic ordy, input logic eRdy, input logic eVal,
                         input logic [31:0] eData, input logic [2:0] eCnt,
                         input logic eShort);
      vec_t v;
      v.inValid  = vi;
      v.inData   = d;
      v.inLast   = l;
      v.outReady = ordy;
      v.expReady = eRdy;
      v.expValid = eVal;
      v.expData  = eData;
      v.expCount = eCnt;
      v.expShort = eShort;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input logic vi, input logic [7:0] d,
                                input logic l, input logic ordy);
      inValid  = vi;
      inData   = d;
      inLast   = l;
      outReady = ordy;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkRow(input string tag, input logic eVal,
                           input logic [31:0] eData, input logic [2:0] eCnt,
                           input logic eShort);
      checkOutput({tag, " out_valid"}, 32'(outValid), 32'(eVal));
      checkOutput({tag, " out_data"},  outData, eData);
      checkOutput({tag, " out_count"}, 32'(outCount), 32'(eCnt));
      checkOutput({tag, " out_short"}, 32'(outShort), 32'(eShort));
   endtask

   initial begin
      logic [31:0] expRow;

      // Full row, short row, single-slice row, back-pressure with PEND
      addVec(1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 3'd0, 1'b0);
      addVec(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 3'd0, 1'b0);
      addVec(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 3'd0, 1'b0);
      addVec(1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 3'd4, 1'b0);
      addVec(1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44332211, 3'd4, 1'b0);
      addVec(1'b1, 8'hB2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000B2A1, 3'd2, 1'b1);
      addVec(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000B2A1, 3'd2, 1'b1);
      addVec(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000005A, 3'd1, 1'b1);
      addVec(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000005A, 3'd1, 1'b1);
      addVec(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000005A, 3'd1, 1'b1);
      addVec(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000005A, 3'd1, 1'b1);
      addVec(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000005A, 3'd1, 1'b1);
      addVec(1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4, 1'b0);
      addVec(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4, 1'b0);
      addVec(1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4, 1'b0);
      addVec(1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4, 1'b0);
      addVec(1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4, 1'b0);
      addVec(1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 32'h04030201, 3'd4, 1'b0);
      addVec(1'b1, 8'h09, 1'b0, 1'b1, 1'b0, 1'b1, 32'h08070605, 3'd4, 1'b0);
      addVec(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h08070605, 3'd4, 1'b0);
      addVec(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h08070605, 3'd4, 1'b0);
      addVec(1'b1, 8'h0A, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000000A, 3'd1, 1'b1);

      // Reset state
      reset = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      tick();
      checkRow("reset", 1'b0, 32'h0, 3'd0, 1'b0);
      reset = 1'b1;
      checkOutput("reset-release in_ready", 32'(inReady), 32'd1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].inValid, vecs[i].inData, vecs[i].inLast, vecs[i].outReady);
         checkOutput($sformatf("vec%0d in_ready", i), 32'(inReady), 32'(vecs[i].expReady));
         tick();
         checkRow($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData,
                  vecs[i].expCount, vecs[i].expShort);
      end

      // Back-to-back single-slice rows: consume and load in the same cycle
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'(8'hC1 + i), 1'b1, 1'b1);
         tick();
         checkRow($sformatf("b2b%0d", i), 1'b1, {24'h0, 8'(8'hC1 + i)}, 3'd1, 1'b1);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      checkOutput("b2b drain out_valid", 32'(outValid), 32'd0);

      // Throughput: 12 slices at full rate, a row every 4 cycles
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
         checkOutput($sformatf("thru%0d in_ready", i), 32'(inReady), 32'd1);
         tick();
         if (i % 4 == 3) begin
            for (int k = 0; k < 4; k++) begin
               expRow[k*8 +: 8] = 8'(8'h10 + i - 3 + k);
            end
            checkRow($sformatf("thru%0d", i), 1'b1, expRow, 3'd4, 1'b0);
         end else begin
            checkOutput($sformatf("thru%0d out_valid", i), 32'(outValid), 32'd0);
         end
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      tick();

      // Reset mid-row: partial row and held output are discarded
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      reset = 1'b0;
      #1;
      checkRow("async-reset", 1'b0, 32'h0, 3'd0, 1'b0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'(i + 1), 1'b0, 1'b1);
         tick();
      end
      checkRow("post-reset", 1'b1, 32'h04030201, 3'd4, 1'b0);
`ifdef ROW_BUFF_STATS_EN
      checkOutput("post-reset stat_rows", statRows, 32'd1);
      checkOutput("post-reset stat_short", statShort, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
